// File: rtl/rob_commit.sv
// Reorder buffer: in-order id allocation, result capture from the rs/lsb buses,
// in-order retire, and mispredict flush. ROB_PERF_CNT_EN adds retire/flush counters.
module rob_commit #(
  parameter int unsigned ROB_SIZE  = 8,
  parameter int unsigned ROB_WIDTH = 3
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  output logic                 rob_full,
  output logic [ROB_WIDTH-1:0] next_rob_id,
  input  logic                 dec_ready,
  input  logic [1:0]           dec_kind,
  input  logic [4:0]           dec_rd,
  input  logic [31:0]          dec_pred_pc,
  input  logic                 rs_ready,
  input  logic [ROB_WIDTH-1:0] rs_rob_id,
  input  logic [31:0]          rs_value,
  input  logic                 lsb_ready,
  input  logic [ROB_WIDTH-1:0] lsb_rob_id,
  input  logic [31:0]          lsb_value,
  input  logic [ROB_WIDTH-1:0] qj_id,
  input  logic [ROB_WIDTH-1:0] qk_id,
  output logic                 qj_ready,
  output logic                 qk_ready,
  output logic [31:0]          qj_value,
  output logic [31:0]          qk_value,
  output logic                 commit_valid,
  output logic [4:0]           commit_rd,
  output logic [31:0]          commit_value,
  output logic [ROB_WIDTH-1:0] commit_rob_id,
  output logic                 store_commit,
  output logic                 clear,
  output logic [31:0]          redirect_pc
`ifdef ROB_PERF_CNT_EN
  ,
  output logic [31:0]          perf_commits,
  output logic [31:0]          perf_mispredicts
`endif
);

  localparam int unsigned CNT_W  = ROB_WIDTH + 1;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;
  localparam logic [1:0]  KIND_STORE  = 2'b01;
  localparam logic [1:0]  KIND_BRANCH = 2'b10;

  // Entry storage
  logic                 r_busy    [ROB_SIZE];
  logic                 r_ready   [ROB_SIZE];
  logic [1:0]           r_kind    [ROB_SIZE];
  logic [REG_W-1:0]     r_rd      [ROB_SIZE];
  logic [DATA_W-1:0]    r_value   [ROB_SIZE];
  logic [DATA_W-1:0]    r_pred_pc [ROB_SIZE];

  logic [ROB_WIDTH-1:0] r_head;
  logic [ROB_WIDTH-1:0] r_tail;
  logic [CNT_W-1:0]     r_count;
  logic                 r_full;

  logic                 r_commit_valid;
  logic [REG_W-1:0]     r_commit_rd;
  logic [DATA_W-1:0]    r_commit_value;
  logic [ROB_WIDTH-1:0] r_commit_rob_id;
  logic                 r_store_commit;
  logic                 r_clear;
  logic [DATA_W-1:0]    r_redirect_pc;

  logic                 w_issue;
  logic                 w_commit;
  logic                 w_flush;
  logic                 w_cap_rs;
  logic                 w_cap_lsb;
  logic [1:0]           w_head_kind;
  logic [DATA_W-1:0]    w_head_value;
  logic [CNT_W-1:0]     w_count_nxt;

  // Issue/commit/capture decisions for this cycle
  always_comb begin
    w_issue      = 1'b0;
    w_commit     = 1'b0;
    w_flush      = 1'b0;
    w_cap_rs     = 1'b0;
    w_cap_lsb    = 1'b0;
    w_head_kind  = r_kind[r_head];
    w_head_value = r_value[r_head];

    w_issue   = dec_ready && !r_full && !r_clear;
    w_commit  = r_busy[r_head] && r_ready[r_head];
    w_flush   = w_commit && (w_head_kind == KIND_BRANCH) &&
                (w_head_value != r_pred_pc[r_head]);
    w_cap_rs  = rs_ready && !r_clear && r_busy[rs_rob_id];
    w_cap_lsb = lsb_ready && !r_clear && r_busy[lsb_rob_id];

    w_count_nxt = r_count + CNT_W'(w_issue) - CNT_W'(w_commit);
  end

  // Operand lookup: live rs bus first, then lsb bus, then stored entry
  always_comb begin
    qj_ready = r_ready[qj_id];
    qj_value = r_value[qj_id];
    if (rs_ready && (rs_rob_id == qj_id)) begin
      qj_ready = 1'b1;
      qj_value = rs_value;
    end else if (lsb_ready && (lsb_rob_id == qj_id)) begin
      qj_ready = 1'b1;
      qj_value = lsb_value;
    end
  end

  always_comb begin
    qk_ready = r_ready[qk_id];
    qk_value = r_value[qk_id];
    if (rs_ready && (rs_rob_id == qk_id)) begin
      qk_ready = 1'b1;
      qk_value = rs_value;
    end else if (lsb_ready && (lsb_rob_id == qk_id)) begin
      qk_ready = 1'b1;
      qk_value = lsb_value;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_head          <= '0;
      r_tail          <= '0;
      r_count         <= '0;
      r_full          <= 1'b0;
      r_commit_valid  <= 1'b0;
      r_commit_rd     <= '0;
      r_commit_value  <= '0;
      r_commit_rob_id <= '0;
      r_store_commit  <= 1'b0;
      r_clear         <= 1'b0;
      r_redirect_pc   <= '0;
      for (int unsigned i = 0; i < ROB_SIZE; i++) begin
        r_busy[i]    <= 1'b0;
        r_ready[i]   <= 1'b0;
        r_kind[i]    <= '0;
        r_rd[i]      <= '0;
        r_value[i]   <= '0;
        r_pred_pc[i] <= '0;
      end
    end else if (rdy_in) begin
      r_commit_valid <= 1'b0;
      r_store_commit <= 1'b0;
      r_clear        <= 1'b0;
      if (w_flush) begin
        // Mispredict: drop everything younger and restart fetch
        r_head        <= '0;
        r_tail        <= '0;
        r_count       <= '0;
        r_full        <= 1'b0;
        r_clear       <= 1'b1;
        r_redirect_pc <= w_head_value;
        for (int unsigned i = 0; i < ROB_SIZE; i++) begin
          r_busy[i]  <= 1'b0;
          r_ready[i] <= 1'b0;
        end
      end else begin
        if (w_commit) begin
          r_busy[r_head] <= 1'b0;
          r_head         <= r_head + ROB_WIDTH'(1);
          if (w_head_kind == KIND_STORE) begin
            r_store_commit  <= 1'b1;
            r_commit_rob_id <= r_head;
          end else if (w_head_kind != KIND_BRANCH) begin
            r_commit_valid  <= 1'b1;
            r_commit_rd     <= r_rd[r_head];
            r_commit_value  <= w_head_value;
            r_commit_rob_id <= r_head;
          end
        end
        if (w_issue) begin
          r_busy[r_tail]    <= 1'b1;
          r_ready[r_tail]   <= 1'b0;
          r_kind[r_tail]    <= dec_kind;
          r_rd[r_tail]      <= dec_rd;
          r_pred_pc[r_tail] <= dec_pred_pc;
          r_tail            <= r_tail + ROB_WIDTH'(1);
        end
        // rs written last so it wins if both buses ever name one entry
        if (w_cap_lsb) begin
          r_value[lsb_rob_id] <= lsb_value;
          r_ready[lsb_rob_id] <= 1'b1;
        end
        if (w_cap_rs) begin
          r_value[rs_rob_id] <= rs_value;
          r_ready[rs_rob_id] <= 1'b1;
        end
        r_count <= w_count_nxt;
        r_full  <= (w_count_nxt == CNT_W'(ROB_SIZE));
      end
    end
  end

  assign rob_full      = r_full;
  assign next_rob_id   = r_tail;
  assign commit_valid  = r_commit_valid;
  assign commit_rd     = r_commit_rd;
  assign commit_value  = r_commit_value;
  assign commit_rob_id = r_commit_rob_id;
  assign store_commit  = r_store_commit;
  assign clear         = r_clear;
  assign redirect_pc   = r_redirect_pc;

`ifdef ROB_PERF_CNT_EN
  logic [31:0] r_perf_commits;
  logic [31:0] r_perf_mispredicts;

  // Retire and flush event counters, free-running with wrap
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_perf_commits     <= '0;
      r_perf_mispredicts <= '0;
    end else if (rdy_in) begin
      if (w_commit) r_perf_commits <= r_perf_commits + 32'(1);
      if (w_flush)  r_perf_mispredicts <= r_perf_mispredicts + 32'(1);
    end
  end

  assign perf_commits     = r_perf_commits;
  assign perf_mispredicts = r_perf_mispredicts;
`endif

endmodule

// File: tb/tb_rob_commit.sv
// Scoreboard bench for rob_commit: directed issue/broadcast sequences with
// hand-computed retire/flush expectations checked by an independent monitor.
module tb_rob_commit;

  localparam int K_REG   = 0;
  localparam int K_STORE = 1;
  localparam int K_CLR   = 2;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        rob_full;
  logic [2:0]  next_rob_id;
  logic        dec_ready = 1'b0;
  logic [1:0]  dec_kind = 2'b00;
  logic [4:0]  dec_rd = '0;
  logic [31:0] dec_pred_pc = '0;
  logic        rs_ready = 1'b0;
  logic [2:0]  rs_rob_id = '0;
  logic [31:0] rs_value = '0;
  logic        lsb_ready = 1'b0;
  logic [2:0]  lsb_rob_id = '0;
  logic [31:0] lsb_value = '0;
  logic [2:0]  qj_id = '0;
  logic [2:0]  qk_id = '0;
  logic        qj_ready, qk_ready;
  logic [31:0] qj_value, qk_value;
  logic        commit_valid;
  logic [4:0]  commit_rd;
  logic [31:0] commit_value;
  logic [2:0]  commit_rob_id;
  logic        store_commit;
  logic        clear;
  logic [31:0] redirect_pc;
`ifdef ROB_PERF_CNT_EN
  logic [31:0] perf_commits;
  logic [31:0] perf_mispredicts;
`endif

  rob_commit #(.ROB_SIZE(8), .ROB_WIDTH(3)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .rob_full(rob_full), .next_rob_id(next_rob_id),
    .dec_ready(dec_ready), .dec_kind(dec_kind), .dec_rd(dec_rd), .dec_pred_pc(dec_pred_pc),
    .rs_ready(rs_ready), .rs_rob_id(rs_rob_id), .rs_value(rs_value),
    .lsb_ready(lsb_ready), .lsb_rob_id(lsb_rob_id), .lsb_value(lsb_value),
    .qj_id(qj_id), .qk_id(qk_id), .qj_ready(qj_ready), .qk_ready(qk_ready),
    .qj_value(qj_value), .qk_value(qk_value),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_value(commit_value),
    .commit_rob_id(commit_rob_id), .store_commit(store_commit),
    .clear(clear), .redirect_pc(redirect_pc)
`ifdef ROB_PERF_CNT_EN
    , .perf_commits(perf_commits), .perf_mispredicts(perf_mispredicts)
`endif
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int          kind;
    logic [4:0]  rd;
    logic [31:0] val;
    logic [2:0]  id;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic push_exp(input int kind, input logic [4:0] rd,
                          input logic [31:0] val, input logic [2:0] id);
    exp_t e;
    e.kind = kind; e.rd = rd; e.val = val; e.id = id;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    tick();
    tick();
    rst_in = 1'b0;
  endtask

  task automatic issue(input logic [1:0] kind, input logic [4:0] rd, input logic [31:0] pred);
    dec_ready = 1'b1; dec_kind = kind; dec_rd = rd; dec_pred_pc = pred;
    tick();
    dec_ready = 1'b0;
  endtask

  task automatic bcast(input logic rv, input logic [2:0] rid, input logic [31:0] rval,
                       input logic lv, input logic [2:0] lid, input logic [31:0] lval);
    rs_ready = rv; rs_rob_id = rid; rs_value = rval;
    lsb_ready = lv; lsb_rob_id = lid; lsb_value = lval;
    tick();
    rs_ready = 1'b0; lsb_ready = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Monitor: every output pulse must match the oldest expected event
  int   m_kind;
  logic m_ok;
  exp_t m_e;
  always @(negedge clk_in) begin
    if (!rst_in && (commit_valid || store_commit || clear)) begin
      m_kind = clear ? K_CLR : (store_commit ? K_STORE : K_REG);
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL out_unexpected kind=%0d id=%0d rd=%0d value=%h pc=%h",
                 m_kind, commit_rob_id, commit_rd, commit_value, redirect_pc);
      end else begin
        m_e = exp_q.pop_front();
        case (m_e.kind)
          K_REG:   m_ok = (m_kind == K_REG) && commit_rd == m_e.rd &&
                          commit_value == m_e.val && commit_rob_id == m_e.id;
          K_STORE: m_ok = (m_kind == K_STORE) && !commit_valid && commit_rob_id == m_e.id;
          default: m_ok = (m_kind == K_CLR) && !commit_valid && !store_commit &&
                          redirect_pc == m_e.val;
        endcase
        if (!m_ok) begin
          failures++;
          $display("FAIL out_compare got kind=%0d cv=%0b sc=%0b id=%0d rd=%0d value=%h pc=%h exp kind=%0d id=%0d rd=%0d value=%h",
                   m_kind, commit_valid, store_commit, commit_rob_id, commit_rd,
                   commit_value, redirect_pc, m_e.kind, m_e.id, m_e.rd, m_e.val);
        end
      end
    end
  end

  initial begin
    // Reset state
    do_reset();
    chk("rst_full", 32'(rob_full), 32'd0);
    chk("rst_next_id", 32'(next_rob_id), 32'd0);
    chk("rst_commit_valid", 32'(commit_valid), 32'd0);
    chk("rst_store_commit", 32'(store_commit), 32'd0);
    chk("rst_clear", 32'(clear), 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    chk("rst_qj_ready", 32'(qj_ready), 32'd0);

    // Single reg-write round trip
    issue(2'b00, 5'd5, 32'd0);
    chk("t1_next_id", 32'(next_rob_id), 32'd1);
    push_exp(K_REG, 5'd5, 32'h1234, 3'd0);
    bcast(1'b1, 3'd0, 32'h1234, 1'b0, 3'd0, 32'd0);
    ticks(3);
    chk("t1_full", 32'(rob_full), 32'd0);

    // Fill, refuse the 9th, out-of-order completion
    do_reset();
    for (int i = 0; i < 8; i++) issue(2'b00, 5'(10 + i), 32'd0);
    chk("t2_full", 32'(rob_full), 32'd1);
    chk("t2_next_id", 32'(next_rob_id), 32'd0);
    issue(2'b00, 5'd31, 32'd0);
    chk("t2_full_after_9th", 32'(rob_full), 32'd1);
    chk("t2_next_id_after_9th", 32'(next_rob_id), 32'd0);
    push_exp(K_REG, 5'd10, 32'h100, 3'd0);
    bcast(1'b1, 3'd3, 32'h33, 1'b1, 3'd0, 32'h100);
    ticks(4);
    chk("t2_full_drain", 32'(rob_full), 32'd0);
    chk("t2_next_id_drain", 32'(next_rob_id), 32'd0);
    push_exp(K_REG, 5'd11, 32'h11, 3'd1);
    push_exp(K_REG, 5'd12, 32'h22, 3'd2);
    push_exp(K_REG, 5'd13, 32'h33, 3'd3);
    bcast(1'b1, 3'd1, 32'h11, 1'b1, 3'd2, 32'h22);
    ticks(5);

    // Mispredict flush, then a correctly predicted branch
    do_reset();
    issue(2'b10, 5'd0, 32'h100);
    issue(2'b00, 5'd1, 32'd0);
    issue(2'b00, 5'd2, 32'd0);
    bcast(1'b1, 3'd1, 32'haa, 1'b1, 3'd2, 32'hbb);
    push_exp(K_CLR, 5'd0, 32'h200, 3'd0);
    bcast(1'b1, 3'd0, 32'h200, 1'b0, 3'd0, 32'd0);
    tick();
    chk("t3_full_after_clear", 32'(rob_full), 32'd0);
    chk("t3_next_id_after_clear", 32'(next_rob_id), 32'd0);
    issue(2'b00, 5'd3, 32'd0);
    chk("t3_issue_during_clear", 32'(next_rob_id), 32'd0);
    ticks(3);
    issue(2'b10, 5'd0, 32'h300);
    issue(2'b00, 5'd7, 32'd0);
    push_exp(K_REG, 5'd7, 32'h77, 3'd1);
    bcast(1'b1, 3'd0, 32'h300, 1'b1, 3'd1, 32'h77);
    ticks(4);

    // Operand lookup bypass and stored values
    do_reset();
    issue(2'b00, 5'd20, 32'd0);
    issue(2'b00, 5'd21, 32'd0);
    issue(2'b00, 5'd22, 32'd0);
    lsb_ready = 1'b1; lsb_rob_id = 3'd2; lsb_value = 32'hdead;
    rs_ready = 1'b1; rs_rob_id = 3'd1; rs_value = 32'hbeef;
    qj_id = 3'd2; qk_id = 3'd1;
    #1;
    chk("t4_qj_ready_bypass", 32'(qj_ready), 32'd1);
    chk("t4_qj_value_bypass", qj_value, 32'hdead);
    chk("t4_qk_ready_bypass", 32'(qk_ready), 32'd1);
    chk("t4_qk_value_bypass", qk_value, 32'hbeef);
    tick();
    rs_ready = 1'b0; lsb_ready = 1'b0;
    #1;
    chk("t4_qj_value_stored", qj_value, 32'hdead);
    chk("t4_qk_value_stored", qk_value, 32'hbeef);
    qj_id = 3'd0;
    #1;
    chk("t4_qj_not_ready", 32'(qj_ready), 32'd0);
    rs_ready = 1'b1; rs_rob_id = 3'd0; rs_value = 32'h1111;
    lsb_ready = 1'b1; lsb_rob_id = 3'd0; lsb_value = 32'h2222;
    #1;
    chk("t4_priority_ready", 32'(qj_ready), 32'd1);
    chk("t4_priority_value", qj_value, 32'h1111);
    rs_ready = 1'b0; lsb_ready = 1'b0;
    #1;
    push_exp(K_REG, 5'd20, 32'h5, 3'd0);
    push_exp(K_REG, 5'd21, 32'hbeef, 3'd1);
    push_exp(K_REG, 5'd22, 32'hdead, 3'd2);
    bcast(1'b1, 3'd0, 32'h5, 1'b0, 3'd0, 32'd0);
    ticks(5);

    // Store retire and kind 11 as reg-write
    do_reset();
    issue(2'b00, 5'd3, 32'd0);
    issue(2'b01, 5'd9, 32'd0);
    issue(2'b11, 5'd4, 32'd0);
    push_exp(K_REG, 5'd3, 32'h10, 3'd0);
    push_exp(K_STORE, 5'd0, 32'd0, 3'd1);
    push_exp(K_REG, 5'd4, 32'h44, 3'd2);
    bcast(1'b1, 3'd0, 32'h10, 1'b1, 3'd1, 32'h2000);
    bcast(1'b1, 3'd2, 32'h44, 1'b0, 3'd0, 32'd0);
    ticks(4);

    // Freeze with a ready head
    do_reset();
    issue(2'b00, 5'd9, 32'd0);
    bcast(1'b1, 3'd0, 32'h99, 1'b0, 3'd0, 32'd0);
    rdy_in = 1'b0;
    dec_ready = 1'b1; dec_kind = 2'b00; dec_rd = 5'd1;
    ticks(3);
    chk("t6_frozen_commit", 32'(commit_valid), 32'd0);
    chk("t6_frozen_next_id", 32'(next_rob_id), 32'd1);
    dec_ready = 1'b0;
    push_exp(K_REG, 5'd9, 32'h99, 3'd0);
    rdy_in = 1'b1;
    tick();
    chk("t6_commit_after_rise", 32'(commit_valid), 32'd1);
    ticks(3);
`ifdef ROB_PERF_CNT_EN
    chk("t6_perf_commits", perf_commits, 32'd1);
    chk("t6_perf_mispredicts", perf_mispredicts, 32'd0);
`endif

    ticks(2);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
